// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared loader state encoding, instruction/PC widths and the
//             reserved-bit mask applied to the length high byte.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int unsigned c_INSN_W = 9;
  localparam int unsigned c_PC_W   = 12;

  localparam logic [7:0] c_LEN_HI_RSVD = 8'hF0;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_INS_LO = 3'd2,
    S_INS_HI = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

endpackage

`default_nettype wire

// File: rtl/loader_ckpt.sv
// ============================================================================
//  Module   : loader_ckpt
//  Purpose  : Byte accumulator holding the running XOR checksum and the low
//             byte of the instruction word being assembled.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module loader_ckpt (
  input  logic       clk,
  input  logic       reset,
  input  logic       xor_en_i,
  input  logic       lo_en_i,
  input  logic [7:0] data_i,
  output logic [7:0] chk_o,
  output logic [7:0] lo_o
);

  logic [7:0] chk_q;
  logic [7:0] lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_q <= 8'h00;
      lo_q  <= 8'h00;
    end else begin
      if (xor_en_i) chk_q <= chk_q ^ data_i;
      if (lo_en_i)  lo_q  <= data_i;
    end
  end

  assign chk_o = chk_q;
  assign lo_o  = lo_q;

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Framed byte-stream program loader; writes 9-bit words into the
//             instruction memory and releases the CPU after a valid frame.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_loader
  import cpu_pkg::*;
#(
  parameter int unsigned D = c_PC_W,
  parameter int unsigned W = c_INSN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         imem_wr_en,
  output logic [D-1:0] imem_wr_addr,
  output logic [W-1:0] imem_wr_dat,
  output logic         cpu_reset,
  output logic         load_done,
  output logic         load_err,
  output logic [D-1:0] word_cnt
);

  state_e         state_q, state_d;
  logic [D-1:0]   len_q, len_d;
  logic [D-1:0]   cnt_q, cnt_d;
  logic           wr_en_q, wr_en_d;
  logic [D-1:0]   wr_addr_q, wr_addr_d;
  logic [W-1:0]   wr_dat_q, wr_dat_d;

  logic           w_accept;
  logic [7:0]     w_chk;
  logic [7:0]     w_lo;

  assign in_ready = (state_q != S_DONE) && (state_q != S_ERR);
  assign w_accept = in_valid && in_ready;

  loader_ckpt u_ckpt (
    .clk      (clk),
    .reset    (reset),
    .xor_en_i (w_accept && (state_q != S_CHK)),
    .lo_en_i  (w_accept && (state_q == S_INS_LO)),
    .data_i   (in_data),
    .chk_o    (w_chk),
    .lo_o     (w_lo)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_dat_d  = wr_dat_q;
    if (w_accept) begin
      case (state_q)
        S_LEN_LO: begin
          len_d[7:0] = in_data;
          state_d    = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d[D-1:8] = in_data[D-9:0];
          if ((in_data & c_LEN_HI_RSVD) != 8'h00)
            state_d = S_ERR;
          else if ({in_data[D-9:0], len_q[7:0]} == '0)
            state_d = S_CHK;
          else
            state_d = S_INS_LO;
        end
        S_INS_LO: state_d = S_INS_HI;
        S_INS_HI: begin
          if (in_data[7:1] != 7'd0) begin
            state_d = S_ERR;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_dat_d  = {in_data[0], w_lo};
            cnt_d     = cnt_q + 1'b1;
            // len never exceeds 2^D-1, so cnt_q reaches len-1 before wrapping
            state_d   = (cnt_q == len_q - 1'b1) ? S_CHK : S_INS_LO;
          end
        end
        S_CHK:   state_d = (in_data == w_chk) ? S_DONE : S_ERR;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_LEN_LO;
      len_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_dat_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_dat_q  <= wr_dat_d;
    end
  end

  assign imem_wr_en   = wr_en_q;
  assign imem_wr_addr = wr_addr_q;
  assign imem_wr_dat  = wr_dat_q;
  assign word_cnt     = cnt_q;
  assign load_done    = (state_q == S_DONE);
  assign load_err     = (state_q == S_ERR);
  assign cpu_reset    = (state_q != S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Scoreboard bench for prog_loader using directed frames.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_wr_en;
  logic [11:0] imem_wr_addr;
  logic [8:0]  imem_wr_dat;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;
  logic [11:0] word_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [11:0] addr;
    logic [8:0]  dat;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frame[$];

  prog_loader dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_wr_en   (imem_wr_en),
    .imem_wr_addr (imem_wr_addr),
    .imem_wr_dat  (imem_wr_dat),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .load_err     (load_err),
    .word_cnt     (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!reset && imem_wr_en) begin
      wr_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%h dat=%h, required none",
                 imem_wr_addr, imem_wr_dat);
      end else begin
        e = exp_q.pop_front();
        if (imem_wr_addr !== e.addr || imem_wr_dat !== e.dat) begin
          fails++;
          $display("FAIL write: got addr=%h dat=%h, required addr=%h dat=%h",
                   imem_wr_addr, imem_wr_dat, e.addr, e.dat);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0, required 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 255);
  endtask

  task automatic send_frame(input int maxgap);
    foreach (frame[i]) send_byte(frame[i], (maxgap == 0) ? 0 : $urandom_range(0, maxgap));
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [8:0] d);
    wr_t e;
    e.addr = a;
    e.dat  = d;
    exp_q.push_back(e);
  endtask

  task automatic settle_and_drain(input string name);
    repeat (3) @(negedge clk);
    check({name, "_pending_writes"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_good(input string name, input logic [11:0] cnt);
    check({name, "_done"},     load_done, 1'b1);
    check({name, "_err"},      load_err,  1'b0);
    check({name, "_cpu_rst"},  cpu_reset, 1'b0);
    check({name, "_ready"},    in_ready,  1'b0);
    check({name, "_word_cnt"}, word_cnt,  cnt);
  endtask

  task automatic check_bad(input string name, input logic [11:0] cnt);
    check({name, "_err"},      load_err,  1'b1);
    check({name, "_done"},     load_done, 1'b0);
    check({name, "_cpu_rst"},  cpu_reset, 1'b1);
    check({name, "_ready"},    in_ready,  1'b0);
    check({name, "_word_cnt"}, word_cnt,  cnt);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_ready"},   in_ready,     1'b1);
    check({name, "_wr_en"},   imem_wr_en,   1'b0);
    check({name, "_wr_addr"}, imem_wr_addr, 12'h000);
    check({name, "_wr_dat"},  imem_wr_dat,  9'h000);
    check({name, "_cpu_rst"}, cpu_reset,    1'b1);
    check({name, "_done"},    load_done,    1'b0);
    check({name, "_err"},     load_err,     1'b0);
    check({name, "_cnt"},     word_cnt,     12'h000);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    do_reset();
    check_reset_state("rst0");

    // Two-word frame, back to back, good checksum
    frame = '{8'h02, 8'h00, 8'h5A, 8'h01, 8'hC3, 8'h00, 8'h9A};
    push_wr(12'h000, 9'h15A);
    push_wr(12'h001, 9'h0C3);
    send_frame(0);
    check_good("good", 12'd2);
    settle_and_drain("good");

    do_reset();
    check_reset_state("rst1");

    // Same frame, wrong checksum: words still land, frame rejected
    frame = '{8'h02, 8'h00, 8'h5A, 8'h01, 8'hC3, 8'h00, 8'h9B};
    push_wr(12'h000, 9'h15A);
    push_wr(12'h001, 9'h0C3);
    send_frame(0);
    check_bad("badchk", 12'd2);
    settle_and_drain("badchk");

    // Empty program
    do_reset();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    check_good("len0", 12'd0);
    settle_and_drain("len0");

    // Reserved bits in length high byte
    do_reset();
    frame = '{8'h02, 8'h10};
    send_frame(0);
    check_bad("rsvd_len", 12'd0);
    settle_and_drain("rsvd_len");

    // Reserved bits in instruction high byte
    do_reset();
    frame = '{8'h01, 8'h00, 8'h5A, 8'h02};
    send_frame(0);
    check_bad("rsvd_ins", 12'd0);
    settle_and_drain("rsvd_ins");

    // Host stalls between bytes
    do_reset();
    frame = '{8'h02, 8'h00, 8'h5A, 8'h01, 8'hC3, 8'h00, 8'h9A};
    push_wr(12'h000, 9'h15A);
    push_wr(12'h001, 9'h0C3);
    send_frame(5);
    check_good("gaps", 12'd2);
    settle_and_drain("gaps");

    // Reset after INS_LO of word 1, then a fresh one-word frame
    do_reset();
    frame = '{8'h02, 8'h00, 8'h5A, 8'h01, 8'hC3};
    push_wr(12'h000, 9'h15A);
    send_frame(0);
    check("midrst_cnt_before", word_cnt, 12'd1);
    settle_and_drain("midrst_partial");
    do_reset();
    check_reset_state("rst_mid");
    frame = '{8'h01, 8'h00, 8'hFF, 8'h01, 8'hFF};
    push_wr(12'h000, 9'h1FF);
    send_frame(0);
    check_good("fresh", 12'd1);
    settle_and_drain("fresh");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
